// File: rtl/fifo.sv
// -----------------------------------------------------------------------------
// fifo -- single-clock synchronous FIFO with selectable read-port behaviour.
//
// Parameters
//   DATA_WIDTH : word width in bits
//   ADDR_WIDTH : address width; depth is 2**ADDR_WIDTH words
//   TYPE       : 0 = registered read (data_out loads one cycle after rd_en)
//                1 = first-word-fall-through (data_out shows the head word)
//
// Ports
//   clk        : clock, all state updates on the rising edge
//   rst        : asynchronous active-low reset
//   data_in    : write data
//   wr_en      : write request, ignored while FIFO_full
//   rd_en      : read request, ignored while FIFO_empty
//   data_out   : read data
//   FIFO_empty : no words stored
//   FIFO_full  : 2**ADDR_WIDTH words stored
//
// Internal signals mem, wptr, rptr and avail keep these exact names so that
// they can be probed hierarchically.
// -----------------------------------------------------------------------------
module fifo #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 5,
    parameter int TYPE       = 0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DATA_WIDTH-1:0] data_in,
    input  logic                  wr_en,
    input  logic                  rd_en,
    output logic [DATA_WIDTH-1:0] data_out,
    output logic                  FIFO_empty,
    output logic                  FIFO_full
);

    localparam int DEPTH = 2 ** ADDR_WIDTH;
    localparam int PW    = ADDR_WIDTH + 1;

    localparam logic [PW-1:0] PTR_ONE   = {{ADDR_WIDTH{1'b0}}, 1'b1};
    localparam logic [PW-1:0] PTR_DEPTH = {1'b1, {ADDR_WIDTH{1'b0}}};

    // Storage; deliberately not reset so contents survive rst.
    logic [DATA_WIDTH-1:0] mem [DEPTH];

    // Pointers carry one extra wrap bit to tell full from empty.
    logic [PW-1:0] wptr_q;
    logic [PW-1:0] wptr_d;
    logic [PW-1:0] rptr_q;
    logic [PW-1:0] rptr_d;
    logic [PW-1:0] wptr;
    logic [PW-1:0] rptr;
    logic [PW-1:0] avail;

    logic wr_fire_s;
    logic rd_fire_s;

    // Flags, free-slot count and accepted-operation strobes from registered pointers.
    always_comb begin
        wptr       = wptr_q;
        rptr       = rptr_q;
        FIFO_empty = (wptr_q == rptr_q);
        FIFO_full  = (wptr_q[ADDR_WIDTH-1:0] == rptr_q[ADDR_WIDTH-1:0]) &&
                     (wptr_q[ADDR_WIDTH] != rptr_q[ADDR_WIDTH]);
        // Modular subtraction handles pointer wrap without extra logic.
        avail      = PTR_DEPTH - (wptr_q - rptr_q);
        // A full FIFO rejects writes even when a read frees a slot this cycle,
        // and an empty FIFO rejects reads even when a write arrives.
        wr_fire_s  = wr_en && !FIFO_full;
        rd_fire_s  = rd_en && !FIFO_empty;
    end

    // Next-state pointer computation.
    always_comb begin
        wptr_d = wptr_q;
        rptr_d = rptr_q;
        if (wr_fire_s) begin
            wptr_d = wptr_q + PTR_ONE;
        end else begin
            wptr_d = wptr_q;
        end
        if (rd_fire_s) begin
            rptr_d = rptr_q + PTR_ONE;
        end else begin
            rptr_d = rptr_q;
        end
    end

    // Pointer registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wptr_q <= {PW{1'b0}};
            rptr_q <= {PW{1'b0}};
        end else begin
            wptr_q <= wptr_d;
            rptr_q <= rptr_d;
        end
    end

    // Memory write port.
    always_ff @(posedge clk) begin
        if (wr_fire_s) begin
            mem[wptr_q[ADDR_WIDTH-1:0]] <= data_in;
        end
    end

    generate
        if (TYPE == 0) begin : g_registered_read
            logic [DATA_WIDTH-1:0] dout_q;
            logic [DATA_WIDTH-1:0] dout_d;

            // Load the head word on an accepted read, otherwise hold.
            always_comb begin
                dout_d = dout_q;
                if (rd_fire_s) begin
                    dout_d = mem[rptr_q[ADDR_WIDTH-1:0]];
                end else begin
                    dout_d = dout_q;
                end
            end

            // Registered read-data output.
            always_ff @(posedge clk or negedge rst) begin
                if (!rst) begin
                    dout_q <= {DATA_WIDTH{1'b0}};
                end else begin
                    dout_q <= dout_d;
                end
            end

            assign data_out = dout_q;
        end else begin : g_fwft_read
            // Head word falls through; rd_en only advances rptr.
            assign data_out = mem[rptr_q[ADDR_WIDTH-1:0]];
        end
    endgenerate

endmodule

// File: tb/tb_fifo.sv
// -----------------------------------------------------------------------------
// tb_fifo -- randomized scoreboard bench for fifo. Two instances run the same
// stimulus: dut0 in registered-read mode and dut1 in first-word-fall-through
// mode. The reference model is a plain queue of words plus modular pointer
// counters; expected read data and write slots are queued by the stimulus and
// consumed by an independent monitor on the falling clock edge.
// -----------------------------------------------------------------------------
module tb_fifo;

    localparam int DW    = 8;
    localparam int AW    = 5;
    localparam int DEPTH = 32;

    logic          clk;
    logic          rst;
    logic [DW-1:0] data_in;
    logic          wr_en;
    logic          rd_en;
    logic [DW-1:0] dout0;
    logic [DW-1:0] dout1;
    logic          empty0;
    logic          full0;
    logic          empty1;
    logic          full1;

    fifo #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .TYPE(0)) dut0 (
        .clk(clk), .rst(rst), .data_in(data_in), .wr_en(wr_en), .rd_en(rd_en),
        .data_out(dout0), .FIFO_empty(empty0), .FIFO_full(full0)
    );

    fifo #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .TYPE(1)) dut1 (
        .clk(clk), .rst(rst), .data_in(data_in), .wr_en(wr_en), .rd_en(rd_en),
        .data_out(dout1), .FIFO_empty(empty1), .FIFO_full(full1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int vectors     = 0;
    int miscompares = 0;

    // Reference model state
    logic [DW-1:0] model_q[$];
    int            m_wptr    = 0;
    int            m_rptr    = 0;
    logic [DW-1:0] last_dout = 8'h00;

    // Scoreboard queues
    logic [DW-1:0] exp_rd_q[$];
    int            exp_wa_q[$];
    logic [DW-1:0] exp_wd_q[$];

    logic [DW-1:0] fill_d[37];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Issue one operation; model decides acceptance from the pre-edge occupancy.
    task automatic cycle(input bit wr, input bit rd, input logic [DW-1:0] d);
        int  cnt;
        bit  wacc;
        bit  racc;
        @(negedge clk);
        #1;
        wr_en   = wr;
        rd_en   = rd;
        data_in = d;
        cnt  = model_q.size();
        wacc = wr && (cnt < DEPTH);
        racc = rd && (cnt > 0);
        if (racc) begin
            exp_rd_q.push_back(model_q.pop_front());
            m_rptr = (m_rptr + 1) % (2 * DEPTH);
        end
        if (wacc) begin
            model_q.push_back(d);
            exp_wa_q.push_back(m_wptr % DEPTH);
            exp_wd_q.push_back(d);
            m_wptr = (m_wptr + 1) % (2 * DEPTH);
        end
    endtask

    task automatic idle();
        cycle(1'b0, 1'b0, 8'h00);
    endtask

    // Monitor: consumes expected results one edge after they were issued.
    int            mon_a;
    logic [DW-1:0] mon_d;
    always @(negedge clk) begin
        if (rst) begin
            if (exp_rd_q.size() > 0) begin
                last_dout = exp_rd_q.pop_front();
            end
            chk("rd_data", dout0, last_dout);
            if (exp_wa_q.size() > 0) begin
                mon_a = exp_wa_q.pop_front();
                mon_d = exp_wd_q.pop_front();
                chk("mem_write", dut0.mem[mon_a], mon_d);
            end
            chk("empty",  empty0, model_q.size() == 0);
            chk("full",   full0,  model_q.size() == DEPTH);
            chk("avail",  dut0.avail, DEPTH - model_q.size());
            chk("wptr",   dut0.wptr, m_wptr);
            chk("rptr",   dut0.rptr, m_rptr);
            chk("empty1", empty1, model_q.size() == 0);
            chk("full1",  full1,  model_q.size() == DEPTH);
            if (model_q.size() > 0) begin
                chk("fwft_data", dout1, model_q[0]);
            end
        end
    end

    initial begin
        rst     = 1'b0;
        wr_en   = 1'b0;
        rd_en   = 1'b0;
        data_in = 8'h00;
        #12;
        chk("rst_empty", empty0, 1'b1);
        chk("rst_full",  full0,  1'b0);
        chk("rst_avail", dut0.avail, 32'd32);
        chk("rst_dout",  dout0, 8'h00);
        chk("rst_wptr",  dut0.wptr, 32'd0);
        chk("rst_rptr",  dut0.rptr, 32'd0);
        @(negedge clk);
        #1;
        rst = 1'b1;

        // Fill: 37 writes, the last five must be dropped
        for (int i = 0; i < 37; i++) begin
            fill_d[i] = 8'($urandom);
            cycle(1'b1, 1'b0, fill_d[i]);
        end
        idle();
        chk("fill_full",  full0, 1'b1);
        chk("fill_avail", dut0.avail, 32'd0);
        chk("fill_wptr",  dut0.wptr, 32'd32);
        for (int i = 0; i < 32; i++) begin
            chk("fill_mem", dut0.mem[i], fill_d[i]);
        end

        // Drain: 37 reads, the last five must leave data_out held
        for (int i = 0; i < 37; i++) begin
            cycle(1'b0, 1'b1, 8'h00);
        end
        idle();
        chk("drain_empty", empty0, 1'b1);
        chk("drain_dout",  dout0, fill_d[31]);
        chk("drain_rptr",  dut0.rptr, 32'd32);

        // Wrap: random mix of reads and writes
        for (int i = 0; i < 320; i++) begin
            cycle(1'($urandom), 1'($urandom), 8'($urandom));
        end
        for (int i = 0; i < 34; i++) begin
            cycle(1'b0, 1'b1, 8'h00);
        end
        idle();
        chk("wrap_empty", empty0, 1'b1);

        // Simultaneous with 5 stored
        for (int i = 0; i < 5; i++) begin
            cycle(1'b1, 1'b0, 8'($urandom));
        end
        cycle(1'b1, 1'b1, 8'($urandom));
        idle();
        chk("simul_mid_avail", dut0.avail, 32'd27);
        for (int i = 0; i < 6; i++) begin
            cycle(1'b0, 1'b1, 8'h00);
        end
        // Simultaneous when empty: write only
        cycle(1'b1, 1'b1, 8'($urandom));
        idle();
        chk("simul_empty_avail", dut0.avail, 32'd31);
        // Simultaneous when full: read only
        for (int i = 0; i < 31; i++) begin
            cycle(1'b1, 1'b0, 8'($urandom));
        end
        idle();
        chk("pre_full", full0, 1'b1);
        cycle(1'b1, 1'b1, 8'($urandom));
        idle();
        chk("simul_full_avail", dut0.avail, 32'd1);
        chk("simul_full_flag",  full0, 1'b0);

        // Reset with 10 stored
        for (int i = 0; i < 32; i++) begin
            cycle(1'b0, 1'b1, 8'h00);
        end
        for (int i = 0; i < 10; i++) begin
            cycle(1'b1, 1'b0, 8'($urandom));
        end
        idle();
        chk("pre_rst_avail", dut0.avail, 32'd22);
        #2;
        rst = 1'b0;
        #1;
        chk("arst_empty", empty0, 1'b1);
        chk("arst_full",  full0,  1'b0);
        chk("arst_avail", dut0.avail, 32'd32);
        chk("arst_dout",  dout0, 8'h00);
        model_q.delete();
        exp_rd_q.delete();
        exp_wa_q.delete();
        exp_wd_q.delete();
        m_wptr    = 0;
        m_rptr    = 0;
        last_dout = 8'h00;
        @(negedge clk);
        #1;
        rst = 1'b1;
        // First operation after reset sees an empty FIFO
        cycle(1'b0, 1'b1, 8'h00);
        idle();

        // FWFT: written word visible before any read
        cycle(1'b1, 1'b0, 8'hA5);
        @(posedge clk);
        #1;
        chk("fwft_a5", dout1, 8'hA5);
        chk("fwft_rptr", dut1.rptr, 32'd0);
        idle();
        cycle(1'b0, 1'b1, 8'h00);
        idle();
        chk("type0_a5", dout0, 8'hA5);
        repeat (2) idle();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
